ins_execute: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Consumes the decoded operation registered out of the decode stage (aluop, alusel, two 32-bit operands, destination, write flag) and produces the write-back triple toward the execute/memory register.
- The same triple is forwarded combinationally to decode as execute_WriteOrNot / execute_DestAddr / execute_Wdata.
- Owns the HI/LO registers and a multi-cycle iterative divider that stalls the pipeline while busy.

---
 rtl/ins_execute.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ins_execute.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_execute.sv
// ---------------------------------------------------------------------------
// ins_execute
// Execute stage of the 5-stage MIPS pipeline.
//
// Purpose:
//   Turns the decoded operation held in the ID/EX register into the
//   write-back triple (enable, destination, data) for the EX/MEM register.
//   The same triple is offered combinationally to decode for forwarding.
//   The stage owns the HI/LO registers and a restoring divider that produces
//   one quotient bit per cycle and stalls the front of the pipeline while it
//   works.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   aluop_input[7:0]    operation code
//   alusel_input[2:0]   result-class selector
//   regOp1[31:0]        operand 1 (rs, or immediate/shamt)
//   regOp2[31:0]        operand 2 (rt, or immediate)
//   dest_addr_input     destination register number
//   write_or_not_input  decode write request
//   flush               squash the instruction in execute (cancels a divide)
//   execute_WriteOrNot  write-back enable
//   execute_DestAddr    write-back register
//   execute_Wdata       write-back data
//   stall_req           hold PC, IF/ID and ID/EX while the divider works
//   hi_output           current HI register
//   lo_output           current LO register
// ---------------------------------------------------------------------------
module ins_execute #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_input,
  input  logic [2:0]  alusel_input,
  input  logic [31:0] regOp1,
  input  logic [31:0] regOp2,
  input  logic [4:0]  dest_addr_input,
  input  logic        write_or_not_input,
  input  logic        flush,
  output logic        execute_WriteOrNot,
  output logic [4:0]  execute_DestAddr,
  output logic [31:0] execute_Wdata,
  output logic        stall_req,
  output logic [31:0] hi_output,
  output logic [31:0] lo_output
);

  // Operation codes shared with the decode stage
  localparam logic [7:0] ALUOP_NOP  = 8'b0000_0000;
  localparam logic [7:0] ALUOP_OR   = 8'b0010_0101;
  localparam logic [7:0] ALUOP_AND  = 8'b0010_0100;
  localparam logic [7:0] ALUOP_XOR  = 8'b0010_0110;
  localparam logic [7:0] ALUOP_NOR  = 8'b0010_0111;
  localparam logic [7:0] ALUOP_SLL  = 8'b0111_1100;
  localparam logic [7:0] ALUOP_SRL  = 8'b0000_0010;
  localparam logic [7:0] ALUOP_SRA  = 8'b0000_0011;
  localparam logic [7:0] ALUOP_SLLV = 8'b0000_0100;
  localparam logic [7:0] ALUOP_SRLV = 8'b0000_0110;
  localparam logic [7:0] ALUOP_SRAV = 8'b0000_0111;
  localparam logic [7:0] ALUOP_MFHI = 8'b0001_0000;
  localparam logic [7:0] ALUOP_MTHI = 8'b0001_0001;
  localparam logic [7:0] ALUOP_MFLO = 8'b0001_0010;
  localparam logic [7:0] ALUOP_MTLO = 8'b0001_0011;
  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
  localparam logic [2:0] ALUSEL_MOVE  = 3'b011;
  localparam logic [2:0] ALUSEL_HILO  = 3'b100;

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_ZERO,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  div_state_e       state_q, state_d;
  logic [31:0]      quot_q;
  logic [31:0]      rem_q;
  logic [31:0]      divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             negQuot_q;
  logic             negRem_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic        isDiv;
  logic        isSigned;
  logic        startDiv;
  logic [32:0] trial;
  logic [32:0] diff;
  logic [31:0] finalQuot;
  logic [31:0] finalRem;
  logic [31:0] resultData;

  assign isDiv    = (aluop_input == ALUOP_DIV) || (aluop_input == ALUOP_DIVU);
  assign isSigned = (aluop_input == ALUOP_DIV);
  // Inputs are only sampled in IDLE; ID/EX is held stable while we stall.
  assign startDiv = (state_q == DIV_IDLE) && isDiv && !flush;

  // Restoring step: the dividend is shifted out of the quotient register
  // into the partial remainder, and a quotient 1 replaces it when the trial
  // subtraction does not borrow. Bit 32 of trial can be set, which is why
  // the subtraction is 33 bits wide.
  assign trial = {rem_q, quot_q[31]};
  assign diff  = trial - {1'b0, divisor_q};

  assign finalQuot = negQuot_q ? (32'd0 - quot_q) : quot_q;
  assign finalRem  = negRem_q  ? (32'd0 - rem_q)  : rem_q;

  assign hi_output = hi_q;
  assign lo_output = lo_q;

  // Divider state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider next-state logic; a flush abandons the divide from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (isDiv && !flush) begin
          state_d = (regOp2 == 32'd0) ? DIV_ZERO : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DIV_DONE;
        end
      end
      DIV_ZERO: state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) begin
      state_d = DIV_IDLE;
    end
  end

  // Divider datapath: operand capture, iteration and zero-divisor result.
  // A zero divisor yields all-ones quotient and the raw dividend as
  // remainder, so the sign fix-up is disabled on that path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (startDiv && (regOp2 != 32'd0)) begin
            negQuot_q <= isSigned && (regOp1[31] ^ regOp2[31]);
            negRem_q  <= isSigned && regOp1[31];
            quot_q    <= (isSigned && regOp1[31]) ? (32'd0 - regOp1) : regOp1;
            divisor_q <= (isSigned && regOp2[31]) ? (32'd0 - regOp2) : regOp2;
            rem_q     <= '0;
            cnt_q     <= '0;
          end
        end
        DIV_BUSY: begin
          quot_q <= {quot_q[30:0], ~diff[32]};
          rem_q  <= diff[32] ? trial[31:0] : diff[31:0];
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        DIV_ZERO: begin
          quot_q    <= 32'hFFFF_FFFF;
          rem_q     <= regOp1;
          negQuot_q <= 1'b0;
          negRem_q  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO: the finished divide lands on the edge leaving DONE, otherwise
  // MTHI/MTLO write them. A flushed instruction never touches them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush) begin
      if (state_q == DIV_DONE) begin
        hi_q <= finalRem;
        lo_q <= finalQuot;
      end else begin
        if (aluop_input == ALUOP_MTHI) begin
          hi_q <= regOp1;
        end
        if (aluop_input == ALUOP_MTLO) begin
          lo_q <= regOp1;
        end
      end
    end
  end

  // Result selection; unknown codes produce 0
  always_comb begin
    resultData = '0;
    unique case (alusel_input)
      ALUSEL_LOGIC: begin
        unique case (aluop_input)
          ALUOP_OR:  resultData = regOp1 | regOp2;
          ALUOP_AND: resultData = regOp1 & regOp2;
          ALUOP_XOR: resultData = regOp1 ^ regOp2;
          ALUOP_NOR: resultData = ~(regOp1 | regOp2);
          default:   resultData = '0;
        endcase
      end
      ALUSEL_SHIFT: begin
        unique case (aluop_input)
          ALUOP_SLL, ALUOP_SLLV: resultData = regOp2 << regOp1[4:0];
          ALUOP_SRL, ALUOP_SRLV: resultData = regOp2 >> regOp1[4:0];
          ALUOP_SRA, ALUOP_SRAV: resultData = $signed(regOp2) >>> regOp1[4:0];
          default:               resultData = '0;
        endcase
      end
      ALUSEL_MOVE: resultData = regOp1;
      ALUSEL_HILO: begin
        unique case (aluop_input)
          ALUOP_MFHI: resultData = hi_q;
          ALUOP_MFLO: resultData = lo_q;
          default:    resultData = '0;
        endcase
      end
      ALUSEL_NOP: resultData = '0;
      default:    resultData = '0;
    endcase
  end

  // Outputs: write-back triple and stall. Everything reads 0 while reset is
  // held. Divides never write a GPR. DONE releases the stall so the
  // pipeline advances on the same edge that writes HI/LO.
  always_comb begin
    execute_WriteOrNot = 1'b0;
    execute_DestAddr   = '0;
    execute_Wdata      = '0;
    stall_req          = 1'b0;
    if (rst) begin
      execute_WriteOrNot = write_or_not_input && !isDiv;
      execute_DestAddr   = dest_addr_input;
      execute_Wdata      = resultData;
      if (!flush) begin
        unique case (state_q)
          DIV_IDLE:           stall_req = isDiv;
          DIV_BUSY, DIV_ZERO: stall_req = 1'b1;
          default:            stall_req = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ins_execute.sv
// ---------------------------------------------------------------------------
// tb_ins_execute
// Scoreboard bench for the execute stage. The driver issues one instruction
// at a time, holding it while stall_req is high like a held ID/EX register,
// and pushes the reference model's expectation. The monitor pops and
// compares when the instruction leaves execute (stall_req low).
// ---------------------------------------------------------------------------
module tb_ins_execute;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_SLLV = 8'h04;
  localparam logic [7:0] OP_SRAV = 8'h07;
  localparam logic [7:0] OP_MOVZ = 8'h0A;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;
  localparam logic [2:0] SEL_HILO  = 3'd4;

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [31:0] hiBefore;
    logic [31:0] loBefore;
    int          stalls;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  destAddr;
  logic        writeReq;
  logic        flushIn;
  logic        exWe;
  logic [4:0]  exDest;
  logic [31:0] exData;
  logic        stallReq;
  logic [31:0] hiOut;
  logic [31:0] loOut;

  exp_t        expQ[$];
  logic        instrValid;
  int          stallCnt;
  int          assertCount;
  int          failCount;
  logic [31:0] mHi;
  logic [31:0] mLo;

  ins_execute #(.DIV_CYCLES(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .aluop_input        (aluop),
    .alusel_input       (alusel),
    .regOp1             (op1),
    .regOp2             (op2),
    .dest_addr_input    (destAddr),
    .write_or_not_input (writeReq),
    .flush              (flushIn),
    .execute_WriteOrNot (exWe),
    .execute_DestAddr   (exDest),
    .execute_Wdata      (exData),
    .stall_req          (stallReq),
    .hi_output          (hiOut),
    .lo_output          (loOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: MIPS semantics with plain arithmetic on the HI/LO state
  task automatic modelStep(input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] dest, input logic we,
                           output exp_t e);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    e.hiBefore = mHi;
    e.loBefore = mLo;
    e.dest     = dest;
    e.we       = we && (op != OP_DIV) && (op != OP_DIVU);
    e.wdata    = 32'd0;
    e.stalls   = 0;
    case (sel)
      SEL_LOGIC: begin
        if (op == OP_OR)  e.wdata = a | b;
        if (op == OP_AND) e.wdata = a & b;
        if (op == OP_XOR) e.wdata = a ^ b;
        if (op == OP_NOR) e.wdata = ~(a | b);
      end
      SEL_SHIFT: begin
        if (op == OP_SLL || op == OP_SLLV) e.wdata = b << a[4:0];
        if (op == OP_SRL)                  e.wdata = b >> a[4:0];
        if (op == OP_SRA || op == OP_SRAV) e.wdata = sb >>> a[4:0];
      end
      SEL_MOVE: e.wdata = a;
      SEL_HILO: begin
        if (op == OP_MFHI) e.wdata = mHi;
        if (op == OP_MFLO) e.wdata = mLo;
      end
      default: e.wdata = 32'd0;
    endcase
    if (op == OP_MTHI) mHi = a;
    if (op == OP_MTLO) mLo = a;
    if (op == OP_DIV || op == OP_DIVU) begin
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
        e.stalls = 2;
      end else begin
        e.stalls = 33;
        if (op == OP_DIVU) begin
          q = a / b;
          r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else begin
          q = sa / sb;
          r = sa % sb;
        end
      end
      mLo = q;
      mHi = r;
    end
  endtask

  // Driver: present an instruction and hold it until execute lets it go
  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] dest, input logic we);
    exp_t e;
    int   cycles;
    logic done;
    aluop    = op;
    alusel   = sel;
    op1      = a;
    op2      = b;
    destAddr = dest;
    writeReq = we;
    flushIn  = 1'b0;
    modelStep(op, sel, a, b, dest, we, e);
    expQ.push_back(e);
    instrValid = 1'b1;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      done = !stallReq;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL timeout: op 0x%02h still stalled after %0d cycles", op, cycles);
      expQ.delete();
    end
    instrValid = 1'b0;
  endtask

  // Monitor: count stall cycles, compare when the instruction completes
  always @(negedge clk) begin
    if (!instrValid || !rst) begin
      stallCnt = 0;
    end else if (stallReq) begin
      stallCnt++;
    end else if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: output with no expectation queued");
    end else begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("we",     {31'd0, exWe},  {31'd0, e.we});
      checkOutput("dest",   {27'd0, exDest}, {27'd0, e.dest});
      checkOutput("wdata",  exData, e.wdata);
      checkOutput("hi",     hiOut, e.hiBefore);
      checkOutput("lo",     loOut, e.loBefore);
      checkOutput("stalls", 32'(stallCnt), 32'(e.stalls));
      stallCnt = 0;
    end
  end

  initial begin
    logic [7:0]  rop;
    logic [2:0]  rsel;
    logic [31:0] ra;
    logic [31:0] rb;
    assertCount = 0;
    failCount   = 0;
    stallCnt    = 0;
    instrValid  = 1'b0;
    mHi = 32'd0;
    mLo = 32'd0;
    rst      = 1'b0;
    flushIn  = 1'b0;
    aluop    = OP_OR;
    alusel   = SEL_LOGIC;
    op1      = 32'h0000_00FF;
    op2      = 32'h0000_0F00;
    destAddr = 5'd3;
    writeReq = 1'b1;

    // Outputs held at zero during reset even with a live instruction present
    #12;
    checkOutput("rst_we",    {31'd0, exWe}, 32'd0);
    checkOutput("rst_dest",  {27'd0, exDest}, 32'd0);
    checkOutput("rst_wdata", exData, 32'd0);
    checkOutput("rst_stall", {31'd0, stallReq}, 32'd0);
    checkOutput("rst_hi",    hiOut, 32'd0);
    checkOutput("rst_lo",    loOut, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed logic/shift/divide sequence");
    applyStimulus(OP_OR,   SEL_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd5, 1'b1);
    applyStimulus(OP_SRA,  SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd6, 1'b1);
    applyStimulus(OP_DIVU, SEL_NOP,   32'd100, 32'd7, 5'd0, 1'b0);
    checkOutput("divu_lo", loOut, 32'd14);
    checkOutput("divu_hi", hiOut, 32'd2);
    applyStimulus(OP_MFLO, SEL_HILO,  32'd0, 32'd0, 5'd3, 1'b1);
    applyStimulus(OP_DIV,  SEL_NOP,   32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
    checkOutput("div_neg_lo", loOut, 32'hFFFF_FFFD);
    checkOutput("div_neg_hi", hiOut, 32'hFFFF_FFFF);
    applyStimulus(OP_DIV,  SEL_NOP,   32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    checkOutput("div_ovf_lo", loOut, 32'h8000_0000);
    checkOutput("div_ovf_hi", hiOut, 32'd0);
    applyStimulus(OP_DIV,  SEL_NOP,   32'd5, 32'd0, 5'd0, 1'b0);
    checkOutput("div_zero_lo", loOut, 32'hFFFF_FFFF);
    checkOutput("div_zero_hi", hiOut, 32'd5);
    applyStimulus(OP_MFHI, SEL_HILO,  32'd0, 32'd0, 5'd9, 1'b1);

    $display("[TB] flush during divide");
    applyStimulus(OP_MTHI, SEL_NOP, 32'h0000_1234, 32'd0, 5'd0, 1'b0);
    applyStimulus(OP_MTLO, SEL_NOP, 32'h0000_1234, 32'd0, 5'd0, 1'b0);
    aluop  = OP_DIVU;
    alusel = SEL_NOP;
    op1    = 32'd100;
    op2    = 32'd7;
    writeReq = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checkOutput("busy_stall", {31'd0, stallReq}, 32'd1);
    flushIn = 1'b1;
    #1;
    checkOutput("flush_stall", {31'd0, stallReq}, 32'd0);
    @(posedge clk);
    #1;
    flushIn = 1'b0;
    aluop   = OP_NOP;
    alusel  = SEL_NOP;
    #1;
    checkOutput("post_flush_stall", {31'd0, stallReq}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush_hi", hiOut, 32'h0000_1234);
    checkOutput("flush_lo", loOut, 32'h0000_1234);
    applyStimulus(OP_DIVU, SEL_NOP, 32'd100, 32'd7, 5'd0, 1'b0);

    $display("[TB] reset during divide");
    aluop  = OP_DIVU;
    alusel = SEL_NOP;
    op1    = 32'd1000;
    op2    = 32'd3;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_stall", {31'd0, stallReq}, 32'd0);
    checkOutput("mid_rst_hi", hiOut, 32'd0);
    checkOutput("mid_rst_lo", loOut, 32'd0);
    aluop    = OP_OR;
    alusel   = SEL_LOGIC;
    op1      = 32'hA5A5_0000;
    destAddr = 5'd7;
    writeReq = 1'b1;
    #1;
    checkOutput("mid_rst_we", {31'd0, exWe}, 32'd0);
    checkOutput("mid_rst_wdata", exData, 32'd0);
    mHi = 32'd0;
    mLo = 32'd0;
    aluop  = OP_NOP;
    alusel = SEL_NOP;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(OP_DIVU, SEL_NOP, 32'd9, 32'd3, 5'd0, 1'b0);
    checkOutput("fresh_lo", loOut, 32'd3);
    checkOutput("fresh_hi", hiOut, 32'd0);

    $display("[TB] randomized instruction mix");
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 13))
        0:  begin rop = OP_OR;   rsel = SEL_LOGIC; end
        1:  begin rop = OP_AND;  rsel = SEL_LOGIC; end
        2:  begin rop = OP_XOR;  rsel = SEL_LOGIC; end
        3:  begin rop = OP_NOR;  rsel = SEL_LOGIC; end
        4:  begin rop = OP_SLL;  rsel = SEL_SHIFT; end
        5:  begin rop = OP_SRL;  rsel = SEL_SHIFT; end
        6:  begin rop = OP_SRAV; rsel = SEL_SHIFT; end
        7:  begin rop = OP_MOVZ; rsel = SEL_MOVE;  end
        8:  begin rop = OP_MFHI; rsel = SEL_HILO;  end
        9:  begin rop = OP_MFLO; rsel = SEL_HILO;  end
        10: begin rop = OP_MTHI; rsel = SEL_NOP;   end
        11: begin rop = OP_MTLO; rsel = SEL_NOP;   end
        12: begin rop = OP_DIV;  rsel = SEL_NOP;   end
        default: begin rop = OP_DIVU; rsel = SEL_NOP; end
      endcase
      if ((rop == OP_DIV || rop == OP_DIVU) && $urandom_range(0, 5) == 0) begin
        rb = 32'd0;
      end
      if ((rop == OP_DIV || rop == OP_DIVU) && $urandom_range(0, 2) == 0) begin
        rb = rb & 32'h0000_00FF;
      end
      applyStimulus(rop, rsel, ra, rb, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    applyStimulus(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

    repeat (2) @(posedge clk);
    if (expQ.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
